// File: rtl/reservation_station_bank_pkg.sv
// Shared types and defaults for the multi-entry reservation station and its
// oldest-ready selector.
package reservation_station_bank_pkg;

  localparam int ROB_TAG_BITS   = 5;
  localparam int RS_ENTRIES_DEF = 4;
  localparam int XLEN_DEF       = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9
  } ALU_FUNC;

  typedef struct packed {
    logic [XLEN_DEF-1:0]     npc;
    logic [XLEN_DEF-1:0]     inst;
    ALU_FUNC                 alu_func;
    logic [ROB_TAG_BITS-1:0] rob_tag;
    logic [XLEN_DEF-1:0]     opa;
    logic [XLEN_DEF-1:0]     opb;
    logic                    opa_valid;
    logic                    opb_valid;
  } RS_DISPATCH_PACKET;

  typedef struct packed {
    logic                    valid;
    logic [XLEN_DEF-1:0]     opa;
    logic [XLEN_DEF-1:0]     opb;
    logic                    opa_valid;
    logic                    opb_valid;
    logic [ROB_TAG_BITS-1:0] opa_tag;
    logic [ROB_TAG_BITS-1:0] opb_tag;
    logic [ROB_TAG_BITS-1:0] rob_tag;
    ALU_FUNC                 alu_func;
    logic [XLEN_DEF-1:0]     npc;
    logic [XLEN_DEF-1:0]     inst;
  } RS_ENTRY;

  typedef struct packed {
    logic [XLEN_DEF-1:0]     opa;
    logic [XLEN_DEF-1:0]     opb;
    logic [XLEN_DEF-1:0]     npc;
    logic [XLEN_DEF-1:0]     inst;
    ALU_FUNC                 alu_func;
    logic [ROB_TAG_BITS-1:0] tag;
  } RS_ISSUE_PACKET;

endpackage

// File: rtl/reservation_station_bank_select.sv
// Combinational age-matrix pick: grants the ready entry that no other ready
// entry is older than. i_age[i][j]=1 means entry j is older than entry i.
module rs_oldest_select #(
  parameter int RS_ENTRIES = 4
) (
  input  logic [RS_ENTRIES-1:0]                 i_ready,
  input  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] i_age,
  output logic [RS_ENTRIES-1:0]                 o_grant,
  output logic                                  o_any
);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if ((j != i) && i_ready[j] && i_age[i][j]) begin
          o_grant[i] = 1'b0;
        end
      end
    end
  end

  assign o_any = |i_ready;

endmodule

// File: rtl/reservation_station_bank.sv
// Multi-entry reservation station: allocates lowest free slot, wakes operands
// from the CDB, and issues the oldest ready entry under valid/ready.
module reservation_station_bank
  import reservation_station_bank_pkg::*;
#(
  parameter int RS_ENTRIES = RS_ENTRIES_DEF,
  parameter int XLEN       = 32,
  parameter int TAG_W      = ROB_TAG_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dispatch_valid,
  input  logic [XLEN-1:0]             dispatch_npc,
  input  logic [XLEN-1:0]             dispatch_inst,
  input  ALU_FUNC                     dispatch_alu_func,
  input  logic [TAG_W-1:0]            dispatch_rob_tag,
  input  logic [XLEN-1:0]             dispatch_opa,
  input  logic [XLEN-1:0]             dispatch_opb,
  input  logic                        dispatch_opa_valid,
  input  logic                        dispatch_opb_valid,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag,
  input  logic [XLEN-1:0]             cdb_value,
  input  logic                        issue_ready,
  input  logic                        rs_clear,
  output logic                        issue_valid,
  output logic [XLEN-1:0]             issue_opa,
  output logic [XLEN-1:0]             issue_opb,
  output logic [XLEN-1:0]             issue_npc,
  output logic [XLEN-1:0]             issue_inst,
  output ALU_FUNC                     issue_alu_func,
  output logic [TAG_W-1:0]            issue_tag,
  output logic                        rs_full,
  output logic [$clog2(RS_ENTRIES):0] rs_free_count
);

  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_ENTRIES-1:0]                 r_valid, r_opa_valid, r_opb_valid;
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] r_age;
  logic [XLEN-1:0]  r_opa [RS_ENTRIES];
  logic [XLEN-1:0]  r_opb [RS_ENTRIES];
  logic [TAG_W-1:0] r_opa_tag [RS_ENTRIES];
  logic [TAG_W-1:0] r_opb_tag [RS_ENTRIES];
  logic [TAG_W-1:0] r_rob_tag [RS_ENTRIES];
  ALU_FUNC          r_func [RS_ENTRIES];
  logic [XLEN-1:0]  r_npc [RS_ENTRIES];
  logic [XLEN-1:0]  r_inst [RS_ENTRIES];

  logic [RS_ENTRIES-1:0]                 w_valid_nxt, w_opa_valid_nxt, w_opb_valid_nxt;
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] w_age_nxt;
  logic [XLEN-1:0]  w_opa_nxt [RS_ENTRIES];
  logic [XLEN-1:0]  w_opb_nxt [RS_ENTRIES];
  logic [TAG_W-1:0] w_opa_tag_nxt [RS_ENTRIES];
  logic [TAG_W-1:0] w_opb_tag_nxt [RS_ENTRIES];
  logic [TAG_W-1:0] w_rob_tag_nxt [RS_ENTRIES];
  ALU_FUNC          w_func_nxt [RS_ENTRIES];
  logic [XLEN-1:0]  w_npc_nxt [RS_ENTRIES];
  logic [XLEN-1:0]  w_inst_nxt [RS_ENTRIES];

  logic [RS_ENTRIES-1:0] w_ready, w_grant, w_free_vec;
  logic                  w_any, w_dispatch, w_found;
  logic [IDX_W-1:0]      w_alloc_idx;
  logic [CNT_W-1:0]      w_free_cnt;
  logic                  w_disp_opa_hit, w_disp_opb_hit;

  // Selection sees registered state only; a flush masks everything out.
  assign w_ready = r_valid & r_opa_valid & r_opb_valid & {RS_ENTRIES{~rs_clear}};

  rs_oldest_select #(.RS_ENTRIES(RS_ENTRIES)) u_select (
    .i_ready (w_ready),
    .i_age   (r_age),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign issue_valid = w_any;
  assign w_free_vec  = w_grant & {RS_ENTRIES{issue_ready}};

  always_comb begin
    issue_opa      = '0;
    issue_opb      = '0;
    issue_npc      = '0;
    issue_inst     = '0;
    issue_alu_func = ALU_ADD;
    issue_tag      = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (w_grant[i]) begin
        issue_opa      = r_opa[i];
        issue_opb      = r_opb[i];
        issue_npc      = r_npc[i];
        issue_inst     = r_inst[i];
        issue_alu_func = r_func[i];
        issue_tag      = r_rob_tag[i];
      end
    end
  end

  always_comb begin
    w_free_cnt = CNT_W'(RS_ENTRIES);
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (r_valid[i]) w_free_cnt = w_free_cnt - 1'b1;
    end
  end

  assign rs_free_count = w_free_cnt;
  assign rs_full       = (w_free_cnt == '0);

  always_comb begin
    w_alloc_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_alloc_idx = IDX_W'(i);
        w_found     = 1'b1;
      end
    end
  end

  assign w_dispatch     = dispatch_valid && !rs_full && !rs_clear;
  assign w_disp_opa_hit = cdb_valid && (cdb_tag == dispatch_opa[TAG_W-1:0]);
  assign w_disp_opb_hit = cdb_valid && (cdb_tag == dispatch_opb[TAG_W-1:0]);

  // Next state: issue free, CDB wakeup, dispatch write, then flush override.
  always_comb begin
    w_valid_nxt     = r_valid & ~w_free_vec;
    w_opa_valid_nxt = r_opa_valid;
    w_opb_valid_nxt = r_opb_valid;
    w_age_nxt       = r_age;
    w_opa_nxt       = r_opa;
    w_opb_nxt       = r_opb;
    w_opa_tag_nxt   = r_opa_tag;
    w_opb_tag_nxt   = r_opb_tag;
    w_rob_tag_nxt   = r_rob_tag;
    w_func_nxt      = r_func;
    w_npc_nxt       = r_npc;
    w_inst_nxt      = r_inst;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (r_valid[i] && !r_opa_valid[i] && cdb_valid && (r_opa_tag[i] == cdb_tag)) begin
        w_opa_valid_nxt[i] = 1'b1;
        w_opa_nxt[i]       = cdb_value;
      end
      if (r_valid[i] && !r_opb_valid[i] && cdb_valid && (r_opb_tag[i] == cdb_tag)) begin
        w_opb_valid_nxt[i] = 1'b1;
        w_opb_nxt[i]       = cdb_value;
      end
      for (int k = 0; k < RS_ENTRIES; k++) begin
        if (w_free_vec[k]) w_age_nxt[i][k] = 1'b0;
      end
    end
    if (w_dispatch) begin
      w_valid_nxt[w_alloc_idx]     = 1'b1;
      w_age_nxt[w_alloc_idx]       = r_valid & ~w_free_vec;
      w_opa_valid_nxt[w_alloc_idx] = dispatch_opa_valid || w_disp_opa_hit;
      w_opb_valid_nxt[w_alloc_idx] = dispatch_opb_valid || w_disp_opb_hit;
      w_opa_nxt[w_alloc_idx]       = (!dispatch_opa_valid && w_disp_opa_hit) ? cdb_value : dispatch_opa;
      w_opb_nxt[w_alloc_idx]       = (!dispatch_opb_valid && w_disp_opb_hit) ? cdb_value : dispatch_opb;
      w_opa_tag_nxt[w_alloc_idx]   = dispatch_opa[TAG_W-1:0];
      w_opb_tag_nxt[w_alloc_idx]   = dispatch_opb[TAG_W-1:0];
      w_rob_tag_nxt[w_alloc_idx]   = dispatch_rob_tag;
      w_func_nxt[w_alloc_idx]      = dispatch_alu_func;
      w_npc_nxt[w_alloc_idx]       = dispatch_npc;
      w_inst_nxt[w_alloc_idx]      = dispatch_inst;
    end
    if (rs_clear) begin
      w_valid_nxt     = '0;
      w_opa_valid_nxt = '0;
      w_opb_valid_nxt = '0;
      w_age_nxt       = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid     <= '0;
      r_opa_valid <= '0;
      r_opb_valid <= '0;
      r_age       <= '0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_opa_valid <= w_opa_valid_nxt;
      r_opb_valid <= w_opb_valid_nxt;
      r_age       <= w_age_nxt;
    end
  end

  // Payload is only observed through a valid grant, so it carries no reset.
  always_ff @(posedge clock) begin
    r_opa     <= w_opa_nxt;
    r_opb     <= w_opb_nxt;
    r_opa_tag <= w_opa_tag_nxt;
    r_opb_tag <= w_opb_tag_nxt;
    r_rob_tag <= w_rob_tag_nxt;
    r_func    <= w_func_nxt;
    r_npc     <= w_npc_nxt;
    r_inst    <= w_inst_nxt;
  end

endmodule

// File: tb/tb_reservation_station_bank.sv
// Directed bench for reservation_station_bank: dispatch, wakeup, bypass,
// age ordering, full/drop, flush and asynchronous reset.
module tb_reservation_station_bank;
  import reservation_station_bank_pkg::*;

  logic        clock, reset;
  logic        dispatch_valid;
  logic [31:0] dispatch_npc, dispatch_inst, dispatch_opa, dispatch_opb;
  ALU_FUNC     dispatch_alu_func;
  logic [4:0]  dispatch_rob_tag;
  logic        dispatch_opa_valid, dispatch_opb_valid;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_ready, rs_clear;
  logic        issue_valid;
  logic [31:0] issue_opa, issue_opb, issue_npc, issue_inst;
  ALU_FUNC     issue_alu_func;
  logic [4:0]  issue_tag;
  logic        rs_full;
  logic [2:0]  rs_free_count;

  int total = 0;
  int bad   = 0;

  reservation_station_bank #(.RS_ENTRIES(4), .XLEN(32), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_npc(dispatch_npc),
    .dispatch_inst(dispatch_inst), .dispatch_alu_func(dispatch_alu_func),
    .dispatch_rob_tag(dispatch_rob_tag), .dispatch_opa(dispatch_opa),
    .dispatch_opb(dispatch_opb), .dispatch_opa_valid(dispatch_opa_valid),
    .dispatch_opb_valid(dispatch_opb_valid), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .issue_ready(issue_ready),
    .rs_clear(rs_clear), .issue_valid(issue_valid), .issue_opa(issue_opa),
    .issue_opb(issue_opb), .issue_npc(issue_npc), .issue_inst(issue_inst),
    .issue_alu_func(issue_alu_func), .issue_tag(issue_tag),
    .rs_full(rs_full), .rs_free_count(rs_free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic disp(input logic [4:0] tag, input logic [31:0] opa, input logic opav,
                      input logic [31:0] opb, input logic opbv);
    dispatch_valid     = 1'b1;
    dispatch_rob_tag   = tag;
    dispatch_opa       = opa;
    dispatch_opa_valid = opav;
    dispatch_opb       = opb;
    dispatch_opb_valid = opbv;
    dispatch_npc       = 32'h1000 + {27'd0, tag};
    dispatch_inst      = 32'h00B0_0000 | {27'd0, tag};
    dispatch_alu_func  = ALU_XOR;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    issue_ready    = 1'b0;
    rs_clear       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #12;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got %0b want 0", issue_valid); end
    total++; if (rs_free_count !== 3'd4) begin bad++; $display("FAIL reset_free_count got %0d want 4", rs_free_count); end
    total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full got %0b want 0", rs_full); end
    total++; if (issue_tag !== 5'd0 || issue_opa !== 32'd0) begin bad++; $display("FAIL reset_issue_data got tag=%0d opa=%h want 0/0", issue_tag, issue_opa); end
  endtask

  task automatic test_basic_issue();
    disp(5'd3, 32'hAAAA_0000, 1'b1, 32'h1, 1'b1);
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL basic_no_same_cycle got %0b want 0", issue_valid); end
    cyc(); idle(); #1;
    total++; if (issue_valid !== 1'b1 || issue_tag !== 5'd3) begin bad++; $display("FAIL basic_issue got v=%0b tag=%0d want 1/3", issue_valid, issue_tag); end
    total++; if (issue_opa !== 32'hAAAA_0000 || issue_opb !== 32'h1) begin bad++; $display("FAIL basic_opnds got %h %h want aaaa0000 00000001", issue_opa, issue_opb); end
    total++; if (issue_npc !== 32'h1003 || issue_alu_func !== ALU_XOR) begin bad++; $display("FAIL basic_payload got npc=%h func=%0d want 1003/%0d", issue_npc, issue_alu_func, ALU_XOR); end
    total++; if (rs_free_count !== 3'd3) begin bad++; $display("FAIL basic_free_after_disp got %0d want 3", rs_free_count); end
    issue_ready = 1'b1;
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd4 || issue_valid !== 1'b0) begin bad++; $display("FAIL basic_freed got free=%0d v=%0b want 4/0", rs_free_count, issue_valid); end
  endtask

  task automatic test_wakeup();
    disp(5'd2, 32'h10, 1'b1, 32'd5, 1'b0);
    cyc(); idle(); #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_waiting0 got %0b want 0", issue_valid); end
    cyc(); #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_waiting1 got %0b want 0", issue_valid); end
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'h1234_5678;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_same_cycle got %0b want 0", issue_valid); end
    cyc(); idle(); #1;
    total++; if (issue_valid !== 1'b1 || issue_tag !== 5'd2 || issue_opb !== 32'h1234_5678) begin bad++; $display("FAIL wake_ready got v=%0b tag=%0d opb=%h want 1/2/12345678", issue_valid, issue_tag, issue_opb); end
    issue_ready = 1'b1;
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd4) begin bad++; $display("FAIL wake_freed got %0d want 4", rs_free_count); end
  endtask

  task automatic test_bypass();
    disp(5'd6, 32'h55, 1'b1, 32'd7, 1'b0);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'hCAFE_F00D;
    cyc(); idle(); #1;
    total++; if (issue_valid !== 1'b1 || issue_tag !== 5'd6 || issue_opb !== 32'hCAFE_F00D) begin bad++; $display("FAIL bypass got v=%0b tag=%0d opb=%h want 1/6/cafef00d", issue_valid, issue_tag, issue_opb); end
    issue_ready = 1'b1;
    cyc(); idle(); #1;
  endtask

  task automatic test_age_full();
    for (int k = 1; k <= 4; k++) begin
      disp(5'(k), 32'(8 + k), 1'b0, 32'h2, 1'b1);
      cyc();
    end
    idle(); #1;
    total++; if (rs_full !== 1'b1 || rs_free_count !== 3'd0) begin bad++; $display("FAIL age_full got full=%0b free=%0d want 1/0", rs_full, rs_free_count); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL age_all_waiting got %0b want 0", issue_valid); end
    disp(5'd5, 32'h1, 1'b1, 32'h1, 1'b1);
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd0 || issue_valid !== 1'b0) begin bad++; $display("FAIL age_drop got free=%0d v=%0b want 0/0", rs_free_count, issue_valid); end
    cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_value = 32'h44;
    cyc(); idle(); #1;
    total++; if (issue_valid !== 1'b1 || issue_tag !== 5'd4) begin bad++; $display("FAIL age_first got v=%0b tag=%0d want 1/4", issue_valid, issue_tag); end
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'h11;
    cyc(); idle(); #1;
    total++; if (issue_tag !== 5'd1 || issue_opa !== 32'h11) begin bad++; $display("FAIL age_preempt got tag=%0d opa=%h want 1/00000011", issue_tag, issue_opa); end
    issue_ready = 1'b1;
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd1 || issue_tag !== 5'd4 || issue_opa !== 32'h44) begin bad++; $display("FAIL age_next got free=%0d tag=%0d opa=%h want 1/4/00000044", rs_free_count, issue_tag, issue_opa); end
    rs_clear = 1'b1;
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd4) begin bad++; $display("FAIL age_cleanup got %0d want 4", rs_free_count); end
  endtask

  task automatic test_back_to_back();
    disp(5'd1, 32'hA1, 1'b1, 32'hB1, 1'b1);
    cyc();
    disp(5'd2, 32'hA2, 1'b1, 32'd20, 1'b0);
    cyc(); idle();
    disp(5'd3, 32'hA3, 1'b1, 32'hB3, 1'b1);
    issue_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_value = 32'hBEEF;
    #1;
    total++; if (issue_tag !== 5'd1) begin bad++; $display("FAIL b2b_first got %0d want 1", issue_tag); end
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd2 || issue_tag !== 5'd2 || issue_opb !== 32'hBEEF) begin bad++; $display("FAIL b2b_combined got free=%0d tag=%0d opb=%h want 2/2/0000beef", rs_free_count, issue_tag, issue_opb); end
    issue_ready = 1'b1;
    cyc(); idle(); #1;
    total++; if (issue_tag !== 5'd3 || rs_free_count !== 3'd3) begin bad++; $display("FAIL b2b_third got tag=%0d free=%0d want 3/3", issue_tag, rs_free_count); end
    issue_ready = 1'b1;
    cyc(); idle(); #1;
  endtask

  task automatic test_clear();
    for (int k = 1; k <= 3; k++) begin
      disp(5'(k), 32'h100, 1'b1, 32'h200, 1'b1);
      cyc();
    end
    idle();
    disp(5'd7, 32'h300, 1'b1, 32'h400, 1'b1);
    #1;
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL clear_pre got %0b want 1", issue_valid); end
    rs_clear = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL clear_forced got %0b want 0", issue_valid); end
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd4 || issue_valid !== 1'b0) begin bad++; $display("FAIL clear_after got free=%0d v=%0b want 4/0", rs_free_count, issue_valid); end
  endtask

  task automatic test_async_reset();
    disp(5'd9, 32'h900, 1'b1, 32'h901, 1'b1);
    cyc();
    disp(5'd10, 32'hA00, 1'b1, 32'hA01, 1'b1);
    cyc(); idle(); #1;
    total++; if (rs_free_count !== 3'd2 || issue_tag !== 5'd9) begin bad++; $display("FAIL areset_pre got free=%0d tag=%0d want 2/9", rs_free_count, issue_tag); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b0 || issue_tag !== 5'd0 || issue_opa !== 32'd0) begin bad++; $display("FAIL areset_issue got v=%0b tag=%0d opa=%h want 0/0/0", issue_valid, issue_tag, issue_opa); end
    total++; if (rs_free_count !== 3'd4 || rs_full !== 1'b0) begin bad++; $display("FAIL areset_count got free=%0d full=%0b want 4/0", rs_free_count, rs_full); end
    #1;
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    dispatch_npc = '0; dispatch_inst = '0; dispatch_opa = '0; dispatch_opb = '0;
    dispatch_alu_func = ALU_ADD; dispatch_rob_tag = '0;
    dispatch_opa_valid = 1'b0; dispatch_opb_valid = 1'b0;
    cdb_tag = '0; cdb_value = '0;
    idle();
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_age_full();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station_bank.md
# reservation_station_bank

Multi-entry, parametrised reservation station that replaces the single-entry `reservation_station`. Sits between dispatch and the ALU issue port, next to `reorder_buffer`. Accepts one dispatched instruction per cycle and wakes waiting operands from CDB broadcasts. Issues the oldest ready entry to the functional unit under a valid/ready handshake, and supports a full flush on mispredict.

## Interface
Parameters:
- `RS_ENTRIES`, 4: number of entries; power of two, ≥2.
- `XLEN`, 32: operand and PC width.
- `TAG_W`, `` `ROB_TAG_BITS``: ROB tag width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dispatch_valid`  in  1  dispatch request.
- `dispatch_npc`, `dispatch_inst`  in  XLEN  carried through to issue.
- `dispatch_alu_func`  in  ALU_FUNC  carried through to issue.
- `dispatch_rob_tag`  in  TAG_W  destination ROB tag.
- `dispatch_opa`, `dispatch_opb`  in  XLEN  operand value; when not valid, low TAG_W bits are the producer ROB tag.
- `dispatch_opa_valid`, `dispatch_opb_valid`  in  1  operand value present.
- `cdb_valid`  in  1  CDB broadcast.
- `cdb_tag`  in  TAG_W  broadcast tag.
- `cdb_value`  in  XLEN  broadcast value.
- `issue_ready`  in  1  FU accepts this cycle.
- `rs_clear`  in  1  synchronous flush.
- `issue_valid`  out  1  an entry is presented.
- `issue_opa`, `issue_opb`, `issue_npc`, `issue_inst`  out  XLEN  issued entry fields.
- `issue_alu_func`  out  ALU_FUNC  issued entry ALU function.
- `issue_tag`  out  TAG_W  issued entry ROB tag.
- `rs_full`  out  1  no free entry.
- `rs_free_count`  out  $clog2(RS_ENTRIES)+1  number of free entries.

## Operation
- Entry state: valid, opa/opb value, opa/opb valid, opa/opb tag, rob tag, alu_func, npc, inst.
- Dispatch is accepted when `dispatch_valid && !rs_full`. It writes the lowest-index free entry. Dispatch while full is dropped silently; the producer must gate on `rs_full`.
- Wakeup: every valid entry whose operand is not valid and whose tag equals `cdb_tag` captures `cdb_value` when `cdb_valid`.
- Dispatch/CDB bypass: if the CDB matches a non-valid dispatch operand tag in the same cycle, the entry is written with that operand already valid, holding `cdb_value`.
- Ready means valid, opa_valid and opb_valid are all set.
- Selection: an age matrix orders entries by dispatch order. `issue_*` shows the oldest ready entry, and `issue_valid` is set when any entry is ready.
- When `issue_valid && issue_ready`, the selected entry is freed at the edge. If `issue_ready` is low, the outputs hold the same oldest-ready entry. An older entry that becomes ready may pre-empt it.
- `rs_clear` invalidates all entries at the edge. It has priority over dispatch, wakeup and the issue handshake. While `rs_clear` is high, `issue_valid` is forced to 0.
- `rs_free_count` equals RS_ENTRIES minus the popcount of valid bits. `rs_full` is high when `rs_free_count == 0`.

## Timing
- Reset (asynchronous) gives: all entries invalid, age matrix zero, `issue_valid=0`, all `issue_*` data outputs 0, `rs_full=0`, `rs_free_count=RS_ENTRIES`.
- Dispatch latency is 1. An entry dispatched fully ready at edge N can issue in cycle N+1.
- Wakeup latency is 1. A CDB broadcast in cycle N makes the entry ready in cycle N+1. There is no same-cycle wakeup-to-issue.
- Issue outputs are combinational from registered state only. There is no combinational path from `cdb_*` or `dispatch_*` to `issue_*`.
- An entry freed by issue at edge N is not reusable until cycle N+1. `rs_full` and `rs_free_count` reflect registered state only.
- Dispatch, issue and CDB may occur in the same cycle, each to a different entry, and all take effect at the same edge.
- Reset asserted mid-operation clears state immediately, regardless of the clock.

## Structure
- Add `RS_ENTRY`, `RS_DISPATCH_PACKET` and `RS_ISSUE_PACKET` typedefs to `sys_defs.svh`.
- Add `` `RS_ENTRIES`` to `sys_defs.svh`, default 4.
- Sub-module `rs_oldest_select`: a purely combinational age-matrix pick. Inputs are the ready vector and the age matrix; outputs are a one-hot grant and `any`.
- The age matrix is updated in the parent. On allocating entry i, row i is set to the current valid vector, so i is younger than all live entries. On free, column i is cleared.

## Test plan
- Reset, then dispatch tag 3 with opa=0xAAAA0000 and opb=0x1 (both valid) -> next cycle `issue_valid=1`, `issue_tag=3`, `issue_opa=0xAAAA0000`. With `issue_ready=1` -> `rs_free_count` returns to 4.
- Dispatch tag 2 with opb waiting on tag 5; CDB tag 5, value 0x12345678, two cycles later -> `issue_valid=0` until the cycle after the broadcast, then `issue_opb=0x12345678`.
- Dispatch with opb waiting on tag 7 while the CDB broadcasts tag 7 in the same cycle -> entry ready next cycle with opb=CDB value.
- Fill 4 entries with tags 1,2,3,4, all waiting; wake tag 4, then tag 1 in the next cycle; hold `issue_ready=0` -> tag 4 shown first, then tag 1 pre-empts (older). `rs_full=1`, and a fifth dispatch is dropped.
- Fill 3 entries, then assert `rs_clear` together with `dispatch_valid` -> `issue_valid=0` that cycle, and next cycle `rs_free_count=4` with nothing captured.
- Assert `reset` between edges with 2 live entries -> outputs go to their reset values immediately, without waiting for a clock edge.
